piece_lock_clear: RTL and testbench

//  Downstream of the falling-piece collision checker. When the game controller finds that a

---
 rtl/piece_lock_clear.sv | 204 ++++++++++++++++++++
 tb/tb_piece_lock_clear.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piece_lock_clear.sv
// rtl/piece_lock_clear.sv - locks a landed piece into board RAM, removes full rows, counts lines
// Optional score output is built when PIECE_LOCK_SCORE_EN is defined.
module piece_lock_clear #(
  parameter int COLS = 10,
  parameter int ROWS = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [4:0] X_anchor,
  input  logic [5:0] Y_anchor,
  input  logic [7:0] cell_x,
  input  logic [7:0] cell_y,
  input  logic [5:0] colour,
  input  logic [5:0] ram_q,
  output logic [7:0] ram_addr,
  output logic [5:0] ram_d,
  output logic       ram_we,
  output logic       busy,
  output logic       done,
  output logic [2:0] lines_cleared
`ifdef PIECE_LOCK_SCORE_EN
  ,
  output logic [15:0] score
`endif
);

  localparam logic [7:0] C8 = 8'(COLS);
  localparam logic [7:0] R8 = 8'(ROWS);

  typedef enum logic [2:0] {IDLE, WRITE, SCAN, SHIFT, CLEARTOP, DONE} state_t;

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [7:0] row, row_n;
  logic [7:0] dst, dst_n;
  logic       phase, phase_n;
  logic       full, full_n;
  logic [2:0] lines, lines_n;
  logic       load;

  logic [4:0] xa;
  logic [5:0] ya;
  logic [7:0] cx, cy;
  logic [5:0] col_s;
  logic [7:0] cell_row, cell_col;

  function automatic logic [7:0] cell_addr(input logic [7:0] r, input logic [7:0] c);
    return 8'(16'(r) * 16'(COLS) + 16'(c));
  endfunction

  assign cell_row      = 8'(ya) + 8'(cy[{cnt[1:0], 1'b0} +: 2]);
  assign cell_col      = 8'(xa) + 8'(cx[{cnt[1:0], 1'b0} +: 2]);
  assign lines_cleared = lines;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      row   <= '0;
      dst   <= '0;
      phase <= 1'b0;
      full  <= 1'b0;
      lines <= '0;
      xa    <= '0;
      ya    <= '0;
      cx    <= '0;
      cy    <= '0;
      col_s <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      row   <= row_n;
      dst   <= dst_n;
      phase <= phase_n;
      full  <= full_n;
      lines <= lines_n;
      if (load) begin
        xa    <= X_anchor;
        ya    <= Y_anchor;
        cx    <= cell_x;
        cy    <= cell_y;
        col_s <= colour;
      end
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    row_n    = row;
    dst_n    = dst;
    phase_n  = phase;
    full_n   = full;
    lines_n  = lines;
    load     = 1'b0;
    ram_addr = '0;
    ram_d    = '0;
    ram_we   = 1'b0;
    busy     = (state != IDLE) && (state != DONE);
    done     = (state == DONE);
    case (state)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_n = WRITE;
          cnt_n   = '0;
          lines_n = '0;
        end
      end
      WRITE: begin
        // Cells falling outside the board are silently dropped.
        if (cell_row < R8 && cell_col < C8) begin
          ram_we   = 1'b1;
          ram_d    = col_s;
          ram_addr = cell_addr(cell_row, cell_col);
        end
        if (cnt == 8'd3) begin
          state_n = SCAN;
          row_n   = R8 - 8'd1;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      SCAN: begin
        // Address for column cnt goes out while ram_q carries column cnt-1.
        if (cnt < C8) ram_addr = cell_addr(row, cnt);
        full_n = (cnt == 8'd0) ? 1'b1 : (full & (|ram_q));
        if (cnt == C8) begin
          cnt_n = '0;
          if (full & (|ram_q)) begin
            lines_n = lines + 3'd1;
            dst_n   = row;
            phase_n = 1'b0;
            state_n = (row == 8'd0) ? CLEARTOP : SHIFT;
          end else if (row == 8'd0) begin
            state_n = DONE;
          end else begin
            row_n = row - 8'd1;
          end
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      SHIFT: begin
        if (!phase) begin
          ram_addr = cell_addr(dst - 8'd1, cnt);
          phase_n  = 1'b1;
        end else begin
          ram_addr = cell_addr(dst, cnt);
          ram_we   = 1'b1;
          ram_d    = ram_q;
          phase_n  = 1'b0;
          if (cnt == C8 - 8'd1) begin
            cnt_n = '0;
            dst_n = dst - 8'd1;
            if (dst == 8'd1) state_n = CLEARTOP;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
      end
      CLEARTOP: begin
        ram_addr = cell_addr(8'd0, cnt);
        ram_we   = 1'b1;
        if (cnt == C8 - 8'd1) begin
          cnt_n = '0;
          // Four lines is the most one piece can complete, so stop scanning.
          state_n = (lines == 3'd4) ? DONE : SCAN;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

`ifdef PIECE_LOCK_SCORE_EN
  function automatic logic [15:0] line_points(input logic [2:0] n);
    case (n)
      3'd1:    return 16'd40;
      3'd2:    return 16'd100;
      3'd3:    return 16'd300;
      3'd4:    return 16'd1200;
      default: return 16'd0;
    endcase
  endfunction

  logic [16:0] score_sum;
  assign score_sum = {1'b0, score} + {1'b0, line_points(lines)};

  // Line count is final on the transition into DONE, so score is current while done is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      score <= '0;
    end else if (state != DONE && state_n == DONE) begin
      score <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_piece_lock_clear.sv
// tb/tb_piece_lock_clear.sv - scoreboard bench for piece_lock_clear with a board-level reference model
// Score checks are compiled in when PIECE_LOCK_SCORE_EN is defined.
module tb_piece_lock_clear;
  localparam int COLS = 10;
  localparam int ROWS = 24;
  localparam int N    = ROWS * COLS;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [4:0] X_anchor = '0;
  logic [5:0] Y_anchor = '0;
  logic [7:0] cell_x = '0;
  logic [7:0] cell_y = '0;
  logic [5:0] colour = '0;
  logic [5:0] ram_q;
  logic [7:0] ram_addr;
  logic [5:0] ram_d;
  logic       ram_we, busy, done;
  logic [2:0] lines_cleared;
`ifdef PIECE_LOCK_SCORE_EN
  logic [15:0] score;
  int          exp_score = 0;
  int          exp_s_q[$];
`endif

  piece_lock_clear #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .reset(reset), .start(start), .X_anchor(X_anchor), .Y_anchor(Y_anchor),
    .cell_x(cell_x), .cell_y(cell_y), .colour(colour), .ram_q(ram_q), .ram_addr(ram_addr),
    .ram_d(ram_d), .ram_we(ram_we), .busy(busy), .done(done), .lines_cleared(lines_cleared)
`ifdef PIECE_LOCK_SCORE_EN
    , .score(score)
`endif
  );

  always #5 clk = ~clk;

  logic [5:0] mem[N];
  logic [5:0] pre_mem[N];
  logic [5:0] exp_mem[N];
  logic       preload = 1'b0;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < N; i++) mem[i] <= pre_mem[i];
    end else if (ram_we && int'(ram_addr) < N) begin
      mem[ram_addr] <= ram_d;
    end
    ram_q <= (int'(ram_addr) < N) ? mem[ram_addr] : 6'd0;
  end

  int compared = 0;
  int mismatched = 0;
  int done_cnt = 0;
  int exp_q[$];
  int mon_lines, mon_bad, mon_first;

  // Monitor: pops one expectation for every done pulse the DUT presents.
  always @(negedge clk) begin
    if (reset) begin
      if (ram_we) begin
        compared++;
        if (int'(ram_addr) >= N) begin
          mismatched++;
          $display("FAIL ram_we_range addr=%0d required below %0d", ram_addr, N);
        end
      end
      if (!busy) begin
        compared++;
        if (ram_we || ram_addr != 8'd0) begin
          mismatched++;
          $display("FAIL idle_ram addr=%0d we=%0b required addr=0 we=0", ram_addr, ram_we);
        end
      end
      if (done) begin
        done_cnt++;
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_done lines=%0d required no done", lines_cleared);
        end else begin
          mon_lines = exp_q.pop_front();
          if (int'(lines_cleared) != mon_lines) begin
            mismatched++;
            $display("FAIL lines_cleared actual=%0d required=%0d", lines_cleared, mon_lines);
          end
          mon_bad = 0;
          mon_first = -1;
          for (int i = 0; i < N; i++)
            if (mem[i] !== exp_mem[i]) begin
              mon_bad++;
              if (mon_first < 0) mon_first = i;
            end
          compared++;
          if (mon_bad != 0) begin
            mismatched++;
            $display("FAIL board %0d cells differ, first addr=%0d actual=%0d required=%0d",
                     mon_bad, mon_first, mem[mon_first], exp_mem[mon_first]);
          end
`ifdef PIECE_LOCK_SCORE_EN
          compared++;
          mon_lines = exp_s_q.pop_front();
          if (int'(score) != mon_lines) begin
            mismatched++;
            $display("FAIL score actual=%0d required=%0d", score, mon_lines);
          end
`endif
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_preload();
    preload = 1'b1;
    tick();
    preload = 1'b0;
  endtask

  function automatic int points(input int n);
    case (n)
      1: return 40;
      2: return 100;
      3: return 300;
      4: return 1200;
      default: return 0;
    endcase
  endfunction

  // Reference: place cells, then keep every row except the lowest (up to four) full ones,
  // stacking survivors at the bottom and padding the top with empty rows.
  task automatic model(input logic [4:0] x, input logic [5:0] y, input logic [7:0] cx,
                       input logic [7:0] cy, input logic [5:0] c, output int nl);
    logic [5:0] b[N];
    int dst;
    bit is_full;
    b = pre_mem;
    for (int i = 0; i < 4; i++) begin
      int r = int'(y) + int'(cy[2*i +: 2]);
      int cc = int'(x) + int'(cx[2*i +: 2]);
      if (r < ROWS && cc < COLS) b[r*COLS + cc] = c;
    end
    for (int k = 0; k < N; k++) exp_mem[k] = '0;
    nl = 0;
    dst = ROWS - 1;
    for (int r = ROWS - 1; r >= 0; r--) begin
      is_full = 1'b1;
      for (int cc = 0; cc < COLS; cc++) if (b[r*COLS + cc] == 6'd0) is_full = 1'b0;
      if (is_full && nl < 4) nl++;
      else begin
        for (int cc = 0; cc < COLS; cc++) exp_mem[dst*COLS + cc] = b[r*COLS + cc];
        dst--;
      end
    end
  endtask

  task automatic issue(input logic [4:0] x, input logic [5:0] y, input logic [7:0] cx,
                       input logic [7:0] cy, input logic [5:0] c);
    int nl;
    model(x, y, cx, cy, c, nl);
    exp_q.push_back(nl);
`ifdef PIECE_LOCK_SCORE_EN
    exp_score = exp_score + points(nl);
    if (exp_score > 65535) exp_score = 65535;
    exp_s_q.push_back(exp_score);
`endif
    X_anchor = x; Y_anchor = y; cell_x = cx; cell_y = cy; colour = c;
    start = 1'b1;
    tick();
    start = 1'b0;
    X_anchor = 5'($urandom); Y_anchor = 6'($urandom);
    cell_x = 8'($urandom); cell_y = 8'($urandom); colour = 6'($urandom);
  endtask

  task automatic wait_done();
    int base;
    int n;
    base = done_cnt;
    n = 0;
    while (done_cnt == base && n < 6000) begin
      tick();
      n++;
    end
    if (done_cnt == base) begin
      compared++;
      mismatched++;
      $display("FAIL done_timeout waited=%0d cycles required a done pulse", n);
      exp_q.delete();
    end
    tick();
    tick();
  endtask

  task automatic clear_board();
    for (int i = 0; i < N; i++) pre_mem[i] = '0;
  endtask

  task automatic sparse_row(input int r);
    for (int cc = 0; cc < COLS; cc++)
      pre_mem[r*COLS + cc] = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(1, 63)) : 6'd0;
  endtask

  task automatic setup_row23();
    clear_board();
    for (int cc = 0; cc < 6; cc++) pre_mem[23*COLS + cc] = 6'd3;
    sparse_row(22);
    do_preload();
  endtask

  task automatic random_board();
    int kind;
    clear_board();
    for (int r = 10; r < ROWS; r++) begin
      kind = $urandom_range(0, 3);
      if (kind == 1) sparse_row(r);
      else if (kind >= 2) begin
        for (int cc = 0; cc < COLS; cc++) pre_mem[r*COLS + cc] = 6'($urandom_range(1, 63));
        if (kind == 3) pre_mem[r*COLS + $urandom_range(0, COLS - 1)] = '0;
      end
    end
    do_preload();
  endtask

  initial begin
    int base;
    int n;
    // Reset state
    repeat (2) @(negedge clk);
    compared++;
    if (ram_addr != 0 || ram_d != 0 || ram_we || busy || done || lines_cleared != 0) begin
      mismatched++;
      $display("FAIL reset_outputs addr=%0d d=%0d we=%0b busy=%0b done=%0b lines=%0d required all 0",
               ram_addr, ram_d, ram_we, busy, done, lines_cleared);
    end
    tick();
    reset = 1'b1;
    tick();

    // O piece on empty board
    clear_board();
    do_preload();
    issue(5'd4, 6'd20, 8'b01000100, 8'b01010000, 6'd5);
    wait_done();

    // Horizontal I completes row 23
    setup_row23();
    issue(5'd6, 6'd23, 8'b11100100, 8'd0, 6'd7);
    wait_done();

    // Vertical I completes rows 20-23
    clear_board();
    for (int r = 20; r < 24; r++)
      for (int cc = 0; cc < 9; cc++) pre_mem[r*COLS + cc] = 6'($urandom_range(1, 63));
    for (int r = 16; r < 20; r++) sparse_row(r);
    do_preload();
    issue(5'd9, 6'd20, 8'd0, 8'b11100100, 6'd2);
    wait_done();

    // Piece hanging off the right edge
    clear_board();
    for (int r = 5; r < ROWS; r++) sparse_row(r);
    do_preload();
    issue(5'd8, 6'd10, 8'b11100100, 8'd0, 6'd4);
    wait_done();

    // Second start while busy, then start coinciding with done
    setup_row23();
    base = done_cnt;
    issue(5'd6, 6'd23, 8'b11100100, 8'd0, 6'd9);
    tick(); tick();
    X_anchor = 5'd0; Y_anchor = 6'd0; cell_x = 8'd0; cell_y = 8'd0; colour = 6'd11;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    @(negedge clk);
    while (!done && n < 6000) begin
      @(negedge clk);
      n++;
    end
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    compared++;
    if (busy) begin
      mismatched++;
      $display("FAIL start_at_done busy=%0b required 0", busy);
    end
    repeat (20) tick();
    compared++;
    if (done_cnt != base + 1) begin
      mismatched++;
      $display("FAIL done_count actual=%0d required=%0d", done_cnt - base, 1);
    end

    // Reset in the middle of the row shift
    setup_row23();
    issue(5'd6, 6'd23, 8'b11100100, 8'd0, 6'd7);
    repeat (40) tick();
    @(negedge clk);
    compared++;
    if (!busy) begin
      mismatched++;
      $display("FAIL busy_in_shift actual=%0b required 1", busy);
    end
    #2 reset = 1'b0;
    #1;
    compared++;
    if (ram_we || busy || done) begin
      mismatched++;
      $display("FAIL abort_outputs we=%0b busy=%0b done=%0b required 0 0 0", ram_we, busy, done);
    end
    exp_q.delete();
`ifdef PIECE_LOCK_SCORE_EN
    exp_s_q.delete();
    exp_score = 0;
`endif
    @(negedge clk);
    compared++;
    if (ram_we || busy || done || lines_cleared != 0) begin
      mismatched++;
      $display("FAIL abort_next we=%0b busy=%0b done=%0b lines=%0d required all 0",
               ram_we, busy, done, lines_cleared);
    end
    tick();
    reset = 1'b1;
    tick();
    setup_row23();
    issue(5'd6, 6'd23, 8'b11100100, 8'd0, 6'd7);
    wait_done();

    // Randomised boards and pieces
    repeat (30) begin
      random_board();
      issue(5'($urandom_range(0, 11)), 6'($urandom_range(0, 24)), 8'($urandom),
            8'($urandom), 6'($urandom_range(1, 63)));
      wait_done();
    end

    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL pending_expectations actual=%0d required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
